// File: rtl/circ_conv_pkg.sv
// circ_conv_pkg: shared definitions for the circular-convolution controller
// and its datapath.
//   state_e      - sequencer state encoding
//   N_DEFAULT    - default number of points
//   MAC_LAT_*    - supported range of MAC latency
//   DRAIN_W      - width of the drain counter, sized for MAC_LAT_MAX
package circ_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned N_DEFAULT   = 8;
  localparam int unsigned MAC_LAT_MIN = 1;
  localparam int unsigned MAC_LAT_MAX = 4;
  localparam int unsigned DRAIN_W     = $clog2(MAC_LAT_MAX + 1);

endpackage

// File: rtl/circ_conv_index_gen.sv
// circ_conv_index_gen: nested term/output counter for the convolution walk.
//   clk_i        - clock
//   reset_i      - asynchronous active-high reset
//   clr_i        - synchronous clear of both counters (wins over en_i)
//   en_i         - advance one term
//   k_o          - term index, wraps at N-1
//   n_o          - output index, advances when k_o wraps
//   last_term_o  - k_o == N-1
//   last_all_o   - last term of the last output (k_o == n_o == N-1)
module circ_conv_index_gen #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] k_o,
  output logic [AW-1:0] n_o,
  output logic          last_term_o,
  output logic          last_all_o
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] n_q, n_d;

  assign last_term_o = (k_q == LAST);
  assign last_all_o  = last_term_o && (n_q == LAST);

  always_comb begin
    k_d = k_q;
    n_d = n_q;
    if (clr_i) begin
      k_d = '0;
      n_d = '0;
    end else if (en_i) begin
      if (last_term_o) begin
        k_d = '0;
        // N is a power of two, so n wraps to 0 after the final output
        n_d = n_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      k_q <= '0;
      n_q <= '0;
    end else begin
      k_q <= k_d;
      n_q <= n_d;
    end
  end

  assign k_o = k_q;
  assign n_o = n_q;

endmodule

// File: rtl/circ_conv_ctrl.sv
// circ_conv_ctrl: sequencer for the N-point circular convolution datapath.
// Walks every output n and term k, issuing x[k] / h[(n-k) mod N] operand
// addresses with MAC clear/accumulate controls, then writes each finished
// accumulator to the result memory after MAC_LAT cycles.
//   clk_i, reset_i       - clock, asynchronous active-high reset
//   start_i              - start request, honoured only in IDLE
//   abort_i              - synchronous cancel back to IDLE, no done
//   x_addr_o, h_addr_o   - operand addresses
//   mac_en_o, mac_clr_o  - product valid / reload accumulator (k == 0)
//   y_we_o, y_addr_o     - result write strobe and index
//   busy_o               - high in RUN and DRAIN
//   done_o               - one-cycle completion pulse
module circ_conv_ctrl
  import circ_conv_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned AW      = $clog2(N),
  parameter int unsigned MAC_LAT = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [AW-1:0] x_addr_o,
  output logic [AW-1:0] h_addr_o,
  output logic          mac_en_o,
  output logic          mac_clr_o,
  output logic          y_we_o,
  output logic [AW-1:0] y_addr_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;

  logic                 cnt_clr, cnt_en;
  logic [AW-1:0]        k, n;
  logic                 last_term, last_all;
  logic                 issue_last;

  // write delay line: stage MAC_LAT-1 drives the result memory
  logic [MAC_LAT-1:0]         we_pipe_q, we_pipe_d;
  logic [MAC_LAT-1:0][AW-1:0] ya_pipe_q, ya_pipe_d;

  circ_conv_index_gen #(
    .N  (N),
    .AW (AW)
  ) u_idx (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .k_o         (k),
    .n_o         (n),
    .last_term_o (last_term),
    .last_all_o  (last_all)
  );

  // next-state logic; counters are held at zero outside RUN so the
  // address outputs read 0 in IDLE/DONE and every run starts at (0,0)
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (last_all) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a start seen in IDLE
    if (abort_i) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
  end

  assign issue_last = (state_q == RUN) && last_term;

  // y_addr is carried only alongside a write so it reads 0 otherwise
  always_comb begin
    we_pipe_d = '0;
    ya_pipe_d = '0;
    if (!abort_i) begin
      we_pipe_d[0] = issue_last;
      ya_pipe_d[0] = issue_last ? n : '0;
      for (int i = 1; i < MAC_LAT; i++) begin
        we_pipe_d[i] = we_pipe_q[i-1];
        ya_pipe_d[i] = ya_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      we_pipe_q <= '0;
      ya_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      we_pipe_q <= we_pipe_d;
      ya_pipe_q <= ya_pipe_d;
    end
  end

  assign x_addr_o  = k;
  // AW-bit subtract gives (n - k) mod N for free since N = 2**AW
  assign h_addr_o  = n - k;
  assign mac_en_o  = (state_q == RUN);
  assign mac_clr_o = (state_q == RUN) && (k == '0);
  assign y_we_o    = we_pipe_q[MAC_LAT-1];
  assign y_addr_o  = ya_pipe_q[MAC_LAT-1];
  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_circ_conv_ctrl.sv
// Directed bench for circ_conv_ctrl: three instances (N=8/LAT=1,
// N=8/LAT=3, N=4/LAT=1) exercised one at a time against a cycle model
// derived from the documented timing.
module tb_circ_conv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] st = '0;
  logic [2:0] ab = '0;

  logic [2:0] xa, ha, ya;  logic ena, clra, wea, busya, donea;
  logic [2:0] xb, hb, yb;  logic enb, clrb, web, busyb, doneb;
  logic [1:0] xc, hc, yc;  logic enc, clrc, wec, busyc, donec;

  circ_conv_ctrl #(.N(8), .AW(3), .MAC_LAT(1)) dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(st[0]), .abort_i(ab[0]),
    .x_addr_o(xa), .h_addr_o(ha), .mac_en_o(ena), .mac_clr_o(clra),
    .y_we_o(wea), .y_addr_o(ya), .busy_o(busya), .done_o(donea));

  circ_conv_ctrl #(.N(8), .AW(3), .MAC_LAT(3)) dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(st[1]), .abort_i(ab[1]),
    .x_addr_o(xb), .h_addr_o(hb), .mac_en_o(enb), .mac_clr_o(clrb),
    .y_we_o(web), .y_addr_o(yb), .busy_o(busyb), .done_o(doneb));

  circ_conv_ctrl #(.N(4), .AW(2), .MAC_LAT(1)) dut_c (
    .clk_i(clk), .reset_i(rst), .start_i(st[2]), .abort_i(ab[2]),
    .x_addr_o(xc), .h_addr_o(hc), .mac_en_o(enc), .mac_clr_o(clrc),
    .y_we_o(wec), .y_addr_o(yc), .busy_o(busyc), .done_o(donec));

  int checks = 0;
  int errors = 0;

  logic [31:0] ox, oh, oen, oclr, owe, oya, obusy, odone;

  // hand-computed N=4 h_addr sequence, (n-k) mod 4 for n,k = 0..3
  int h4_tab [16] = '{0,3,2,1, 1,0,3,2, 2,1,0,3, 3,2,1,0};

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int sel);
    case (sel)
      0: begin ox = 32'(xa); oh = 32'(ha); oen = 32'(ena); oclr = 32'(clra);
               owe = 32'(wea); oya = 32'(ya); obusy = 32'(busya); odone = 32'(donea); end
      1: begin ox = 32'(xb); oh = 32'(hb); oen = 32'(enb); oclr = 32'(clrb);
               owe = 32'(web); oya = 32'(yb); obusy = 32'(busyb); odone = 32'(doneb); end
      default: begin ox = 32'(xc); oh = 32'(hc); oen = 32'(enc); oclr = 32'(clrc);
               owe = 32'(wec); oya = 32'(yc); obusy = 32'(busyc); odone = 32'(donec); end
    endcase
  endtask

  task automatic check_idle(input int sel, input string tag, input int cyc);
    sample(sel);
    chk({tag, "_x"}, cyc, ox, 0);     chk({tag, "_h"}, cyc, oh, 0);
    chk({tag, "_en"}, cyc, oen, 0);   chk({tag, "_clr"}, cyc, oclr, 0);
    chk({tag, "_we"}, cyc, owe, 0);   chk({tag, "_ya"}, cyc, oya, 0);
    chk({tag, "_busy"}, cyc, obusy, 0); chk({tag, "_done"}, cyc, odone, 0);
  endtask

  // Start pulse at edge 0, then check every cycle against the timing model.
  // abort_cyc>0 raises abort during that cycle; pulses=1 re-pulses start
  // while busy and in DONE, which must have no effect.
  task automatic check_run(input int sel, input int np, input int lat,
                           input int abort_cyc, input bit pulses,
                           input int exp_we_cnt);
    int total, en_cnt, we_cnt;
    int k, n, t;
    bit alive, run, we;
    total  = np*np + lat + 4;
    en_cnt = 0;
    we_cnt = 0;
    st[sel] = 1'b1;
    step();
    st[sel] = 1'b0;
    for (int cyc = 1; cyc <= total; cyc++) begin
      sample(sel);
      alive = !(abort_cyc > 0 && cyc > abort_cyc);
      run   = alive && cyc <= np*np;
      k     = (cyc - 1) % np;
      n     = (cyc - 1) / np;
      t     = cyc - lat;
      we    = alive && t >= np && t <= np*np && (t % np) == 0;
      chk("x_addr", cyc, ox, run ? k : 0);
      chk("h_addr", cyc, oh, run ? ((n - k) & (np - 1)) : 0);
      chk("mac_en", cyc, oen, run ? 1 : 0);
      chk("mac_clr", cyc, oclr, (run && k == 0) ? 1 : 0);
      chk("y_we", cyc, owe, we ? 1 : 0);
      chk("y_addr", cyc, oya, we ? (t / np - 1) : 0);
      chk("busy", cyc, obusy, (alive && cyc <= np*np + lat) ? 1 : 0);
      chk("done", cyc, odone, (alive && cyc == np*np + lat + 1) ? 1 : 0);
      if (np == 4 && run) chk("h4_table", cyc, oh, h4_tab[cyc-1]);
      if (oen[0]) en_cnt++;
      if (owe[0]) we_cnt++;
      if (cyc == abort_cyc) ab[sel] = 1'b1;
      if (pulses && (cyc == 5 || cyc == 10 || cyc == np*np + lat + 1)) st[sel] = 1'b1;
      step();
      ab[sel] = 1'b0;
      st[sel] = 1'b0;
    end
    chk("mac_en_count", total, en_cnt, (abort_cyc > 0) ? abort_cyc : np*np);
    chk("y_we_count", total, we_cnt, exp_we_cnt);
  endtask

  initial begin
    // reset held with start high on every instance: nothing may happen
    st  = 3'b111;
    rst = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_idle(0, "rstA", c); check_idle(1, "rstB", c); check_idle(2, "rstC", c);
      step();
    end
    st  = '0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_idle(0, "idleA", c); check_idle(1, "idleB", c); check_idle(2, "idleC", c);
    end

    // full runs: N=8/LAT=1, N=8/LAT=3, N=4/LAT=1 with ignored start pulses
    check_run(0, 8, 1, 0, 1'b0, 8);
    check_run(1, 8, 3, 0, 1'b0, 8);
    check_run(2, 4, 1, 0, 1'b1, 4);

    // abort in cycle 20, then a fresh run replays from n=0
    check_run(0, 8, 1, 20, 1'b0, 2);
    step();
    check_run(0, 8, 1, 0, 1'b0, 8);

    // abort with LAT=3 while the n=1 write is still in the delay line
    check_run(1, 8, 3, 17, 1'b0, 1);

    // start and abort together in IDLE: stays idle
    st[0] = 1'b1; ab[0] = 1'b1;
    step();
    st[0] = 1'b0; ab[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_idle(0, "startabort", c);
      step();
    end

    // start held high: runs of 66 cycles separated by one IDLE cycle
    st[0] = 1'b1;
    step();
    for (int cyc = 1; cyc <= 205; cyc++) begin
      int p;
      sample(0);
      p = (cyc - 1) % 67;
      if (cyc <= 200) begin
        chk("held_busy", cyc, obusy, (p < 65) ? 1 : 0);
        chk("held_done", cyc, odone, (p == 65) ? 1 : 0);
        chk("held_en", cyc, oen, (p < 64) ? 1 : 0);
        chk("held_x", cyc, ox, (p < 64) ? (p % 8) : 0);
      end else begin
        chk("held_busy", cyc, obusy, 0);
        chk("held_done", cyc, odone, 0);
        chk("held_en", cyc, oen, 0);
      end
      st[0] = (cyc < 200);
      step();
    end
    st[0] = 1'b0;

    // asynchronous reset mid-run: outputs clear at once, no done afterwards
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    repeat (29) step();
    sample(0);
    chk("pre_reset_busy", 30, obusy, 1);
    #2 rst = 1'b1;
    #1 check_idle(0, "async_rst", 30);
    step();
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      sample(0);
      chk("post_rst_done", c, odone, 0);
      chk("post_rst_busy", c, obusy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
